ami_w: RTL and testbench



---
 rtl/ami_w_if.sv | 55 +++++
 rtl/ami_w.sv | 108 ++++++++++
 tb/tb_ami_w.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ami_w_if.sv
// ami_w_if: user command/beat/response signals plus AXI4 AW, W and B channels of the write master.
interface ami_w_if #(
    parameter int AXI_DW     = 128,
    parameter int AXI_AW     = 40,
    parameter int AXI_IW     = 8,
    parameter int AXI_LW     = 8,
    parameter int AXI_SW     = 3,
    parameter int AXI_BURSTW = 2,
    parameter int AXI_BRESPW = 2,
    parameter int AXI_WSTRBW = AXI_DW/8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [AXI_AW-1:0]     cmd_addr;
    logic [AXI_LW-1:0]     cmd_len;
    logic [AXI_IW-1:0]     cmd_id;
    logic                  cmd_err;
    logic [AXI_DW-1:0]     usr_wdata;
    logic [AXI_WSTRBW-1:0] usr_wstrb;
    logic                  usr_wvalid;
    logic                  usr_wready;
    logic                  usr_bvalid;
    logic [AXI_IW-1:0]     usr_bid;
    logic [AXI_BRESPW-1:0] usr_bresp;
    logic [AXI_IW-1:0]     AWID;
    logic [AXI_AW-1:0]     AWADDR;
    logic [AXI_LW-1:0]     AWLEN;
    logic [AXI_SW-1:0]     AWSIZE;
    logic [AXI_BURSTW-1:0] AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [AXI_DW-1:0]     WDATA;
    logic [AXI_WSTRBW-1:0] WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;
    logic [AXI_IW-1:0]     BID;
    logic [AXI_BRESPW-1:0] BRESP;
    logic                  BVALID;
    logic                  BREADY;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, cmd_id, usr_wdata, usr_wstrb, usr_wvalid,
               AWREADY, WREADY, BID, BRESP, BVALID,
        output cmd_ready, cmd_err, usr_wready, usr_bvalid, usr_bid, usr_bresp,
               AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, cmd_id, usr_wdata, usr_wstrb, usr_wvalid,
               AWREADY, WREADY, BID, BRESP, BVALID,
        input  cmd_ready, cmd_err, usr_wready, usr_bvalid, usr_bid, usr_bresp,
               AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY
    );
endinterface

// File: rtl/ami_w.sv
// ami_w: AXI4 write master issuing INCR full-width bursts with up to MST_OD writes awaiting B.
module ami_w #(
    parameter int AXI_DW     = 128,
    parameter int AXI_AW     = 40,
    parameter int AXI_IW     = 8,
    parameter int AXI_LW     = 8,
    parameter int AXI_SW     = 3,
    parameter int AXI_BURSTW = 2,
    parameter int AXI_BRESPW = 2,
    parameter int AXI_WSTRBW = AXI_DW/8,
    parameter int MST_OD     = 4
) (
    input logic    ACLK,
    input logic    ARESET,
    ami_w_if.master bus
);
    localparam int SZ = $clog2(AXI_WSTRBW);
    localparam int OW = $clog2(MST_OD+1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                r_state, w_next;
    logic [OW-1:0]         r_os;
    logic [AXI_LW-1:0]     r_beat, r_len;
    logic [AXI_AW-1:0]     r_addr;
    logic [AXI_IW-1:0]     r_id, r_bid;
    logic [AXI_SW-1:0]     r_size;
    logic [AXI_BURSTW-1:0] r_burst;
    logic [AXI_BRESPW-1:0] r_bresp;
    logic                  r_err, r_bv;
    logic [13:0]           w_span;
    logic                  w_acc, w_bad, w_aw, w_w, w_b, w_last, w_data;

    // Burst end offset within the 4 KB page; exactly 4096 still fits.
    assign w_span = {2'b0, bus.cmd_addr[11:0]} + ((14'(bus.cmd_len) + 14'd1) << SZ);
    assign w_bad  = ((bus.cmd_addr & AXI_AW'(AXI_WSTRBW-1)) != '0) || (w_span > 14'd4096);
    assign w_acc  = bus.cmd_valid && bus.cmd_ready;
    assign w_data = r_state == DATA;
    assign w_aw   = r_state == ADDR && bus.AWREADY;
    assign w_w    = w_data && bus.usr_wvalid && bus.WREADY;
    assign w_last = r_beat == r_len;
    assign w_b    = bus.BVALID && bus.BREADY;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_acc && !w_bad) ? ADDR : IDLE;
            ADDR:    w_next = bus.AWREADY ? DATA : ADDR;
            DATA:    w_next = (w_w && w_last) ? IDLE : DATA;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= IDLE;
            r_os    <= '0;
            r_beat  <= '0;
            r_len   <= '0;
            r_addr  <= '0;
            r_id    <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
            r_bv    <= 1'b0;
            r_bid   <= '0;
            r_bresp <= '0;
        end else begin
            r_state <= w_next;
            r_err   <= w_acc && w_bad;
            r_bv    <= w_b;
            if (w_acc) begin
                r_addr  <= bus.cmd_addr;
                r_len   <= bus.cmd_len;
                r_id    <= bus.cmd_id;
                r_size  <= AXI_SW'(SZ);
                r_burst <= AXI_BURSTW'(1);
            end
            if (w_aw) r_beat <= '0;
            else if (w_w) r_beat <= r_beat + 1'b1;
            // Coincident AW and B cancel; a stray B never underflows.
            if (w_aw && !w_b) r_os <= r_os + 1'b1;
            else if (w_b && !w_aw && r_os != '0) r_os <= r_os - 1'b1;
            if (w_b) begin
                r_bid   <= bus.BID;
                r_bresp <= bus.BRESP;
            end
        end
    end

    assign bus.cmd_ready  = !ARESET && r_state == IDLE && r_os < OW'(MST_OD);
    assign bus.cmd_err    = r_err;
    assign bus.AWVALID    = r_state == ADDR;
    assign bus.AWADDR     = r_addr;
    assign bus.AWLEN      = r_len;
    assign bus.AWID       = r_id;
    assign bus.AWSIZE     = r_size;
    assign bus.AWBURST    = r_burst;
    assign bus.WVALID     = w_data && bus.usr_wvalid;
    assign bus.usr_wready = w_data && bus.WREADY;
    assign bus.WDATA      = w_data ? bus.usr_wdata : '0;
    assign bus.WSTRB      = w_data ? bus.usr_wstrb : '0;
    assign bus.WLAST      = w_data && w_last;
    assign bus.BREADY     = !ARESET;
    assign bus.usr_bvalid = r_bv;
    assign bus.usr_bid    = r_bid;
    assign bus.usr_bresp  = r_bresp;
endmodule

// File: tb/tb_ami_w.sv
// tb_ami_w: directed checks of ami_w command checking, AW/W sequencing, outstanding limit, B forwarding and reset.
module tb_ami_w;
  logic clk_i = 1'b0;
  logic ACLK;
  logic ARESET;
  int errors = 0;
  int checks = 0;
  int hs;
  assign ACLK = clk_i;
  ami_w_if bus ();
  ami_w dut (.ACLK(ACLK), .ARESET(ARESET), .bus(bus));
  always #5 clk_i = ~clk_i;
  task automatic tick();
    @(posedge ACLK);
    #2;
  endtask
  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] D(int k);
    return {4{32'hA500_0000 + 32'(k)}};
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    ARESET = 1'b1;
    bus.cmd_valid = 0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_id = '0;
    bus.usr_wdata = '0; bus.usr_wstrb = '1; bus.usr_wvalid = 0;
    bus.AWREADY = 0; bus.WREADY = 0; bus.BID = '0; bus.BRESP = '0; bus.BVALID = 0;
    repeat (2) tick();
    chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("rst_awvalid", bus.AWVALID, 1'b0);
    chk("rst_wvalid", bus.WVALID, 1'b0);
    chk("rst_usr_wready", bus.usr_wready, 1'b0);
    chk("rst_bready", bus.BREADY, 1'b0);
    chk("rst_usr_bvalid", bus.usr_bvalid, 1'b0);
    chk("rst_cmd_err", bus.cmd_err, 1'b0);
    chk("rst_awaddr", bus.AWADDR, 40'h0);
    chk("rst_wlast", bus.WLAST, 1'b0);
    ARESET = 1'b0; #1;
    chk("idle_cmd_ready", bus.cmd_ready, 1'b1);
    chk("idle_bready", bus.BREADY, 1'b1);
    bus.cmd_valid = 1; bus.cmd_addr = 40'h100; bus.cmd_len = 0; bus.cmd_id = 3;
    bus.usr_wvalid = 1; bus.usr_wdata = D(0);
    tick(); bus.cmd_valid = 0; #1;
    chk("s_awvalid", bus.AWVALID, 1'b1);
    chk("s_awaddr", bus.AWADDR, 40'h100);
    chk("s_awlen", bus.AWLEN, 8'd0);
    chk("s_awsize", bus.AWSIZE, 3'd4);
    chk("s_awburst", bus.AWBURST, 2'b01);
    chk("s_awid", bus.AWID, 8'd3);
    chk("s_w_before_aw", bus.WVALID, 1'b0);
    chk("s_cmd_ready_busy", bus.cmd_ready, 1'b0);
    bus.AWREADY = 1;
    tick(); bus.AWREADY = 0; #1;
    chk("s_aw_dropped", bus.AWVALID, 1'b0);
    chk("s_wvalid", bus.WVALID, 1'b1);
    chk("s_wlast", bus.WLAST, 1'b1);
    chk("s_wdata", bus.WDATA, D(0));
    bus.WREADY = 1; #1;
    chk("s_usr_wready", bus.usr_wready, 1'b1);
    tick(); bus.WREADY = 0; bus.usr_wvalid = 0; #1;
    chk("s_cmd_ready_after", bus.cmd_ready, 1'b1);
    chk("s_wvalid_after", bus.WVALID, 1'b0);
    bus.BVALID = 1; bus.BID = 3; bus.BRESP = 0;
    tick(); bus.BVALID = 0;
    chk("s_usr_bvalid", bus.usr_bvalid, 1'b1);
    chk("s_usr_bid", bus.usr_bid, 8'd3);
    chk("s_usr_bresp", bus.usr_bresp, 2'b00);
    tick();
    chk("s_usr_bvalid_pulse", bus.usr_bvalid, 1'b0);
    bus.cmd_valid = 1; bus.cmd_addr = 40'h200; bus.cmd_len = 15; bus.cmd_id = 5; bus.AWREADY = 1;
    tick(); bus.cmd_valid = 0;
    tick(); bus.AWREADY = 0;
    hs = 0; bus.usr_wvalid = 1;
    for (int c = 0; c < 36; c++) begin
      bus.usr_wdata = D(hs); bus.WREADY = 1'(c & 1); #1;
      if (bus.WVALID && bus.WREADY) begin
        checks++;
        if (bus.WDATA !== D(hs)) begin
          errors++;
          $error("FAIL b16_wdata observed=%0h expected=%0h", bus.WDATA, D(hs));
        end
        checks++;
        if (bus.WLAST !== 1'(hs == 15)) begin
          errors++;
          $error("FAIL b16_wlast observed=%0h expected=%0h", bus.WLAST, 1'(hs == 15));
        end
        hs++;
      end
      tick();
    end
    bus.usr_wvalid = 0; bus.WREADY = 0; #1;
    chk("b16_handshakes", hs, 16);
    chk("b16_idle_ready", bus.cmd_ready, 1'b1);
    bus.BVALID = 1; bus.BID = 5; bus.BRESP = 0;
    tick(); bus.BVALID = 0;
    chk("b16_usr_bid", bus.usr_bid, 8'd5);
    bus.cmd_valid = 1; bus.cmd_addr = 40'hFF0; bus.cmd_len = 1;
    tick(); bus.cmd_valid = 0;
    chk("x4k_err", bus.cmd_err, 1'b1);
    chk("x4k_no_aw", bus.AWVALID, 1'b0);
    tick();
    chk("x4k_err_pulse", bus.cmd_err, 1'b0);
    chk("x4k_no_aw2", bus.AWVALID, 1'b0);
    chk("x4k_ready", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1; bus.cmd_addr = 40'h104; bus.cmd_len = 0;
    tick(); bus.cmd_valid = 0;
    chk("unal_err", bus.cmd_err, 1'b1);
    chk("unal_no_aw", bus.AWVALID, 1'b0);
    tick();
    chk("unal_err_pulse", bus.cmd_err, 1'b0);
    bus.cmd_valid = 1; bus.cmd_addr = 40'hFF0; bus.cmd_len = 0;
    tick(); bus.cmd_valid = 0;
    chk("edge4k_no_err", bus.cmd_err, 1'b0);
    chk("edge4k_aw", bus.AWVALID, 1'b1);
    bus.AWREADY = 1;
    tick(); bus.AWREADY = 0; bus.usr_wvalid = 1; bus.WREADY = 1;
    tick(); bus.usr_wvalid = 0; bus.WREADY = 0;
    bus.BVALID = 1;
    tick(); bus.BVALID = 0;
    bus.AWREADY = 1; bus.WREADY = 1; bus.usr_wvalid = 1;
    bus.cmd_addr = 40'h0; bus.cmd_len = 0; bus.cmd_id = 1;
    for (int i = 0; i < 4; i++) begin
      bus.cmd_valid = 1; #1;
      chk("od_ready", bus.cmd_ready, 1'b1);
      tick(); bus.cmd_valid = 0;
      tick();
      tick();
    end
    bus.cmd_valid = 1; #1;
    chk("od_full", bus.cmd_ready, 1'b0);
    repeat (3) tick();
    chk("od_full_no_aw", bus.AWVALID, 1'b0);
    chk("od_full_hold", bus.cmd_ready, 1'b0);
    bus.BVALID = 1; bus.BID = 2; bus.BRESP = 0;
    tick(); bus.BVALID = 0;
    chk("od_b_pulse", bus.usr_bvalid, 1'b1);
    chk("od_ready_after_b", bus.cmd_ready, 1'b1);
    tick();
    chk("od_fifth_aw", bus.AWVALID, 1'b1);
    bus.BVALID = 1;
    tick(); bus.BVALID = 0;
    tick(); bus.cmd_valid = 0; #1;
    chk("od_aw_b_same", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1;
    tick(); bus.cmd_valid = 0;
    tick();
    tick();
    chk("od_full_again", bus.cmd_ready, 1'b0);
    bus.BVALID = 1; bus.BID = 7; bus.BRESP = 2'b10;
    tick();
    chk("slv_bvalid", bus.usr_bvalid, 1'b1);
    chk("slv_bid", bus.usr_bid, 8'd7);
    chk("slv_bresp", bus.usr_bresp, 2'b10);
    tick();
    chk("slv_b2b", bus.usr_bvalid, 1'b1);
    chk("slv_dec", bus.cmd_ready, 1'b1);
    tick();
    tick(); bus.BVALID = 0;
    chk("slv_b2b_last", bus.usr_bvalid, 1'b1);
    tick();
    chk("slv_b_end", bus.usr_bvalid, 1'b0);
    bus.BVALID = 1; bus.BID = 9; bus.BRESP = 2'b01;
    tick(); bus.BVALID = 0;
    chk("stray_b_fwd", bus.usr_bvalid, 1'b1);
    chk("stray_b_id", bus.usr_bid, 8'd9);
    chk("stray_no_underflow", bus.cmd_ready, 1'b1);
    bus.AWREADY = 0; bus.WREADY = 0; bus.usr_wvalid = 0;
    bus.cmd_valid = 1; bus.cmd_addr = 40'h300; bus.cmd_len = 7; bus.cmd_id = 4; bus.AWREADY = 1;
    tick(); bus.cmd_valid = 0;
    tick(); bus.AWREADY = 0; bus.usr_wvalid = 1; bus.WREADY = 1;
    repeat (5) tick();
    chk("mid_wvalid", bus.WVALID, 1'b1);
    chk("mid_wlast", bus.WLAST, 1'b0);
    ARESET = 1;
    tick();
    chk("mr_wvalid", bus.WVALID, 1'b0);
    chk("mr_usr_wready", bus.usr_wready, 1'b0);
    chk("mr_awvalid", bus.AWVALID, 1'b0);
    chk("mr_awaddr", bus.AWADDR, 40'h0);
    chk("mr_awlen", bus.AWLEN, 8'd0);
    chk("mr_cmd_ready", bus.cmd_ready, 1'b0);
    chk("mr_bready", bus.BREADY, 1'b0);
    chk("mr_wlast", bus.WLAST, 1'b0);
    ARESET = 0; bus.usr_wvalid = 0; bus.WREADY = 0; #1;
    chk("mr_ready_after", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1; bus.cmd_addr = 40'h400; bus.cmd_len = 1; bus.cmd_id = 6; bus.AWREADY = 1;
    tick(); bus.cmd_valid = 0;
    chk("pr_awaddr", bus.AWADDR, 40'h400);
    chk("pr_awlen", bus.AWLEN, 8'd1);
    tick(); bus.AWREADY = 0; bus.usr_wvalid = 1; bus.WREADY = 1; bus.usr_wdata = D(0); #1;
    chk("pr_wlast0", bus.WLAST, 1'b0);
    tick(); bus.usr_wdata = D(1); #1;
    chk("pr_wlast1", bus.WLAST, 1'b1);
    chk("pr_wdata1", bus.WDATA, D(1));
    tick(); bus.usr_wvalid = 0; bus.WREADY = 0;
    chk("pr_done", bus.WVALID, 1'b0);
    bus.BVALID = 1; bus.BID = 6; bus.BRESP = 0;
    tick(); bus.BVALID = 0;
    chk("pr_bvalid", bus.usr_bvalid, 1'b1);
    chk("pr_bid", bus.usr_bid, 8'd6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
